// File: rtl/rgb_pwm_sequencer_pkg.sv
// rtl/rgb_pwm_sequencer_pkg.sv - command modes, pattern states and entry-state helper
package rgb_pwm_sequencer_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SOLID     = 3'd1,
        ST_BLINK_ON  = 3'd2,
        ST_BLINK_OFF = 3'd3,
        ST_RAMP_UP   = 3'd4,
        ST_RAMP_DOWN = 3'd5
    } state_t;

    function automatic state_t mode_entry(input logic [1:0] mode);
        case (mode)
            MODE_SOLID:   return ST_SOLID;
            MODE_BLINK:   return ST_BLINK_ON;
            MODE_BREATHE: return ST_RAMP_UP;
            default:      return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// rtl/rgb_pwm_timebase.sv - prescaled PWM counter with frame boundary strobe
module rgb_pwm_timebase #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 47
) (
    input  logic             int_osc,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_strobe
);

    localparam int              PW         = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [PW-1:0] presc;
    logic          tick;

    assign tick         = (presc == PRESC_LAST);
    assign frame_strobe = tick && (cnt == CNT_MAX);

    always_ff @(posedge int_osc or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - three-channel OFF/SOLID/BLINK/BREATHE PWM sequencer
module rgb_pwm_sequencer
    import rgb_pwm_sequencer_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int PRESCALE     = 47,
    parameter int BLINK_FRAMES = 244,
    parameter int BREATHE_STEP = 4
) (
    input  logic               int_osc,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [3*CNT_W-1:0] cmd_rgb,
    output logic               pwm_red,
    output logic               pwm_green,
    output logic               pwm_blue,
    output logic               frame_strobe,
    output logic [1:0]         mode_active
);

    localparam int               FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0]    BLINK_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STEP       = CNT_W'(BREATHE_STEP);

    logic [CNT_W-1:0]   cnt;
    logic               boundary;
    state_t             state, state_nx;
    logic [CNT_W-1:0]   level, level_nx;
    logic [FW-1:0]      frame_cnt, frame_cnt_nx;
    logic [3*CNT_W-1:0] rgb_q, rgb_nx;
    logic [1:0]         mode_q, mode_nx;
    logic               pend_vld, pend_vld_nx;
    logic [1:0]         pend_mode, pend_mode_nx;
    logic [3*CNT_W-1:0] pend_rgb, pend_rgb_nx;
    logic [CNT_W:0]     up_sum;
    logic [CNT_W-1:0]   duty_r, duty_g, duty_b;

    rgb_pwm_timebase #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .int_osc      (int_osc),
        .rst_n        (rst_n),
        .cnt          (cnt),
        .frame_strobe (boundary)
    );

    assign frame_strobe = boundary;
    assign cmd_ready    = ~pend_vld;
    assign mode_active  = mode_q;
    assign up_sum       = {1'b0, level} + {1'b0, STEP};

    function automatic logic [CNT_W-1:0] scale(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lv);
        logic [2*CNT_W-1:0] p;
        p = {{CNT_W{1'b0}}, c} * {{CNT_W{1'b0}}, lv};
        return CNT_W'(p >> CNT_W);
    endfunction

    always_ff @(posedge int_osc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            level     <= '0;
            frame_cnt <= '0;
            rgb_q     <= '0;
            mode_q    <= MODE_OFF;
            pend_vld  <= 1'b0;
            pend_mode <= MODE_OFF;
            pend_rgb  <= '0;
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            state     <= state_nx;
            level     <= level_nx;
            frame_cnt <= frame_cnt_nx;
            rgb_q     <= rgb_nx;
            mode_q    <= mode_nx;
            pend_vld  <= pend_vld_nx;
            pend_mode <= pend_mode_nx;
            pend_rgb  <= pend_rgb_nx;
            pwm_red   <= (cnt < duty_r);
            pwm_green <= (cnt < duty_g);
            pwm_blue  <= (cnt < duty_b);
        end
    end

    // A pending command and a pattern step are mutually exclusive at a boundary.
    always_comb begin
        state_nx     = state;
        level_nx     = level;
        frame_cnt_nx = frame_cnt;
        rgb_nx       = rgb_q;
        mode_nx      = mode_q;
        pend_vld_nx  = pend_vld;
        pend_mode_nx = pend_mode;
        pend_rgb_nx  = pend_rgb;

        if (cmd_valid && !pend_vld) begin
            pend_vld_nx  = 1'b1;
            pend_mode_nx = cmd_mode;
            pend_rgb_nx  = cmd_rgb;
        end

        if (boundary) begin
            if (pend_vld) begin
                pend_vld_nx  = 1'b0;
                rgb_nx       = pend_rgb;
                mode_nx      = pend_mode;
                state_nx     = mode_entry(pend_mode);
                level_nx     = '0;
                frame_cnt_nx = '0;
            end else begin
                case (state)
                    ST_BLINK_ON, ST_BLINK_OFF: begin
                        if (frame_cnt == BLINK_LAST) begin
                            frame_cnt_nx = '0;
                            state_nx     = (state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
                        end else begin
                            frame_cnt_nx = frame_cnt + 1'b1;
                        end
                    end
                    ST_RAMP_UP: begin
                        if (up_sum >= {1'b0, CNT_MAX}) begin
                            level_nx = CNT_MAX;
                            state_nx = ST_RAMP_DOWN;
                        end else begin
                            level_nx = up_sum[CNT_W-1:0];
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (level <= STEP) begin
                            level_nx = '0;
                            state_nx = ST_RAMP_UP;
                        end else begin
                            level_nx = level - STEP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (state)
            ST_SOLID, ST_BLINK_ON: begin
                duty_r = rgb_q[3*CNT_W-1 -: CNT_W];
                duty_g = rgb_q[2*CNT_W-1 -: CNT_W];
                duty_b = rgb_q[CNT_W-1:0];
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
                duty_r = scale(rgb_q[3*CNT_W-1 -: CNT_W], level);
                duty_g = scale(rgb_q[2*CNT_W-1 -: CNT_W], level);
                duty_b = scale(rgb_q[CNT_W-1:0], level);
            end
            default: ;
        endcase
    end

endmodule
